// File: rtl/port_uart_tx.sv
// port_uart_tx: captures CPU OUT writes to the high-nibble port and transmits the
// combined 8-bit port value {Port[1],Port[0]} as a serial frame (start, 8 data LSB first, stop).
module port_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       port_write,
   input  logic       port_sel,
   input  logic [7:0] port_data,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_ovf
);

   localparam int unsigned STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
   localparam int unsigned CNT_W     = $clog2(STOP_CLKS) + 1;

   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_e;

   state_e           state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q,   shift_d;
   logic [7:0]       hold_q,    hold_d;
   logic             pending_q, pending_d;
   logic             strobe_q,  strobe_d;
   logic             ovf_q,     ovf_d;
   logic             tx_q,      tx_d;
   logic             busy_q,    busy_d;
   logic             done_q,    done_d;
   logic             drain_s;

   // Next-state logic: frame sequencer, holding-register capture and registered outputs
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      hold_d    = hold_q;
      pending_d = pending_q;
      ovf_d     = ovf_q;
      strobe_d  = port_write & port_sel;
      drain_s   = (state_q == S_IDLE) && pending_q;

      case (state_q)
         S_IDLE: begin
            if (pending_q) begin
               shift_d   = hold_q;
               pending_d = 1'b0;
               state_d   = S_START;
               cnt_d     = BIT_LAST;
               bit_idx_d = 3'd0;
            end else begin
               cnt_d     = CNT_ZERO;
               bit_idx_d = 3'd0;
            end
         end
         S_START: begin
            if (cnt_q == CNT_ZERO) begin
               state_d   = S_DATA;
               cnt_d     = BIT_LAST;
               bit_idx_d = 3'd0;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_ZERO) begin
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
                  cnt_d   = STOP_LAST;
               end else begin
                  shift_d   = {1'b0, shift_q[7:1]};
                  bit_idx_d = bit_idx_q + 3'd1;
                  cnt_d     = BIT_LAST;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_STOP: begin
            if (cnt_q == CNT_ZERO) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d   = S_IDLE;
            cnt_d     = CNT_ZERO;
            bit_idx_d = 3'd0;
         end
      endcase

      // A capture in the drain cycle refills the holding register instead of overflowing
      if (strobe_q) begin
         if (pending_q && !drain_s) begin
            ovf_d = 1'b1;
         end else begin
            hold_d    = port_data;
            pending_d = 1'b1;
         end
      end else begin
         hold_d = hold_d;
      end

      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase

      busy_d = (state_d != S_IDLE) | pending_d;
      done_d = (state_d == S_STOP) && (cnt_d == CNT_ZERO);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= CNT_ZERO;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'd0;
         hold_q    <= 8'd0;
         pending_q <= 1'b0;
         strobe_q  <= 1'b0;
         ovf_q     <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         hold_q    <= hold_d;
         pending_q <= pending_d;
         strobe_q  <= strobe_d;
         ovf_q     <= ovf_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign tx      = tx_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;
   assign tx_ovf  = ovf_q;

endmodule

// File: tb/tb_port_uart_tx.sv
// Bench for port_uart_tx: one instance with 1 stop bit and one with 2, driven in parallel and
// compared every cycle against a frame-schedule model (frame start times, pending window, overflow).
module tb_port_uart_tx;
   localparam int CPB = 4;
   localparam int BIG = 32'h7fffffff;

   typedef struct {
      int         n;
      int         s;
      logic [7:0] d;
   } frame_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       port_write;
   logic       port_sel;
   logic [7:0] port_data;
   logic [1:0] tx, tx_busy, tx_done, tx_ovf;

   frame_t     fq0[$];
   frame_t     fq1[$];
   int         ovf_from[2];
   int         cyc;
   int         checks;
   int         failures;
   int         due_cyc;
   logic [7:0] due_byte;
   logic [7:0] wr_byte;

   always #5 clk = ~clk;

   port_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
      .clk(clk), .reset(reset), .port_write(port_write), .port_sel(port_sel),
      .port_data(port_data), .tx(tx[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]),
      .tx_ovf(tx_ovf[0])
   );

   port_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
      .clk(clk), .reset(reset), .port_write(port_write), .port_sel(port_sel),
      .port_data(port_data), .tx(tx[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]),
      .tx_ovf(tx_ovf[1])
   );

   function automatic int flen(input int d);
      return (9 + d + 1) * CPB;
   endfunction

   task automatic check_eq(input string tag, input logic obs, input logic exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0b expected=%0b", tag, cyc, obs, exp);
      end
   endtask

   // A write in cycle n is captured at the end of cycle n+1 and starts a frame at n+3 when idle.
   task automatic model_write(input int d, input int n, input logic [7:0] b);
      frame_t q[$];
      frame_t f;
      int     cap;
      int     s;
      q   = (d == 0) ? fq0 : fq1;
      cap = n + 1;
      if (q.size() > 0 && cap < q[$].s - 1) begin
         if (ovf_from[d] > n + 2) ovf_from[d] = n + 2;
      end else begin
         s = n + 3;
         if (q.size() > 0 && q[$].s + flen(d) + 1 > s) s = q[$].s + flen(d) + 1;
         f.n = n;
         f.s = s;
         f.d = b;
         q.push_back(f);
      end
      if (d == 0) fq0 = q; else fq1 = q;
   endtask

   task automatic model_check(input int d);
      frame_t q[$];
      logic   e_tx, e_busy, e_done, e_ovf;
      int     o, bi, fl;
      q      = (d == 0) ? fq0 : fq1;
      fl     = flen(d);
      e_tx   = 1'b1;
      e_busy = 1'b0;
      e_done = 1'b0;
      foreach (q[i]) begin
         if (q[i].n + 2 <= cyc && cyc < q[i].s + fl) e_busy = 1'b1;
         if (cyc >= q[i].s && cyc < q[i].s + fl) begin
            o  = cyc - q[i].s;
            bi = o / CPB;
            if (bi == 0) e_tx = 1'b0;
            else if (bi <= 8) e_tx = q[i].d[bi-1];
            else e_tx = 1'b1;
         end
         if (cyc == q[i].s + fl - 1) e_done = 1'b1;
      end
      e_ovf = (cyc >= ovf_from[d]);
      check_eq($sformatf("tx%0d", d + 1),   tx[d],      e_tx);
      check_eq($sformatf("busy%0d", d + 1), tx_busy[d], e_busy);
      check_eq($sformatf("done%0d", d + 1), tx_done[d], e_done);
      check_eq($sformatf("ovf%0d", d + 1),  tx_ovf[d],  e_ovf);
      while (q.size() > 0 && cyc > q[0].s + fl) void'(q.pop_front());
      if (d == 0) fq0 = q; else fq1 = q;
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) begin
         fq0.delete();
         fq1.delete();
         ovf_from[0] = BIG;
         ovf_from[1] = BIG;
         due_cyc     = -1;
      end else if (port_write && port_sel) begin
         model_write(0, cyc, wr_byte);
         model_write(1, cyc, wr_byte);
         due_cyc  = cyc + 1;
         due_byte = wr_byte;
      end
      cyc++;
      #1;
      port_data = (cyc == due_cyc) ? due_byte : 8'($urandom);
      model_check(0);
      model_check(1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic write(input logic sel, input logic [7:0] b);
      port_write = 1'b1;
      port_sel   = sel;
      wr_byte    = b;
      tick();
      port_write = 1'b0;
      port_sel   = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      port_write  = 1'b0;
      port_sel    = 1'b0;
      port_data   = 8'h00;
      wr_byte     = 8'h00;
      due_byte    = 8'h00;
      due_cyc     = -1;
      cyc         = 0;
      checks      = 0;
      failures    = 0;
      ovf_from[0] = BIG;
      ovf_from[1] = BIG;

      tick();
      tick();
      reset = 1'b0;
      idle(100);

      write(1'b0, 8'h05);
      write(1'b1, 8'hA5);
      idle(50);

      write(1'b0, 8'h07);
      idle(20);

      write(1'b1, 8'h3C);
      idle(10);
      write(1'b1, 8'hC3);
      idle(100);

      write(1'b1, 8'h11);
      idle(5);
      write(1'b1, 8'h22);
      idle(5);
      write(1'b1, 8'h33);
      idle(120);
      do_reset();
      idle(5);

      // Abort during data bit 3: first START cycle is two cycles after the write's next cycle
      write(1'b1, 8'hFF);
      idle(2 + 4 * CPB + 1);
      do_reset();
      idle(3);
      write(1'b1, 8'h81);
      idle(60);

      for (int k = 0; k < 250; k++) begin
         if ($urandom_range(0, 39) == 0) do_reset();
         write(($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0, 8'($urandom));
         idle($urandom_range(0, 60));
      end
      idle(120);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
